// File: rtl/led_pkg.sv
// Shared wiring-mode encodings and elaboration-time helpers for the LED address mapper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_LINEAR    = 2'b00,
    MODE_ROW_SERP  = 2'b01,
    MODE_COL_SERP  = 2'b10,
    MODE_CUBE_SERP = 2'b11
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counter width that stays legal when a dimension collapses to a single entry.
  function automatic int cnt_w(input int value);
    return (value > 1) ? clog2(value) : 1;
  endfunction

endpackage

// File: rtl/led_addr_calc.sv
// Combinational logical (x,y,z) to physical address remap; shared with the readout scan path.
module led_addr_calc
  import led_pkg::*;
#(
  parameter  int COLS   = 8,
  parameter  int ROWS   = 8,
  parameter  int LAYERS = 8,
  localparam int ADDR_W = clog2(COLS * ROWS * LAYERS),
  localparam int XW     = cnt_w(COLS),
  localparam int YW     = cnt_w(ROWS),
  localparam int ZW     = cnt_w(LAYERS)
) (
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  input  logic [ZW-1:0]     z_i,
  input  mode_e             mode_i,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int CS = clog2(COLS);
  localparam int RS = clog2(ROWS);

  logic [ADDR_W-1:0] xa, ya, za;
  logic [ADDR_W-1:0] layer_base, row_p, col_p, lin_p;

  always_comb begin
    xa = ADDR_W'(x_i);
    ya = ADDR_W'(y_i);
    za = ADDR_W'(z_i);
    layer_base = za << (CS + RS);
    lin_p = (ya << CS) + xa;
    row_p = (ya << CS) + (y_i[0] ? (ADDR_W'(COLS - 1) - xa) : xa);
    col_p = (xa << RS) + (x_i[0] ? (ADDR_W'(ROWS - 1) - ya) : ya);

    case (mode_i)
      MODE_LINEAR:    addr_o = layer_base + lin_p;
      MODE_ROW_SERP:  addr_o = layer_base + row_p;
      MODE_COL_SERP:  addr_o = layer_base + col_p;
      MODE_CUBE_SERP: addr_o = layer_base +
                               (z_i[0] ? (ADDR_W'(COLS * ROWS - 1) - row_p) : row_p);
      default:        addr_o = layer_base + lin_p;
    endcase
  end

endmodule

// File: rtl/led_addr_mapper.sv
// Streaming pixel-to-address mapper: X/Y/Z beat counter, per-frame mode latch and
// a single valid/ready output register feeding the frame-buffer write port.
module led_addr_mapper
  import led_pkg::*;
#(
  parameter  int COLS   = 8,
  parameter  int ROWS   = 8,
  parameter  int LAYERS = 8,
  parameter  int DATA_W = 24,
  localparam int ADDR_W = clog2(COLS * ROWS * LAYERS)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [1:0]        Mode,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic              In_sof,
  input  logic [DATA_W-1:0] In_data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [ADDR_W-1:0] Out_addr,
  output logic [DATA_W-1:0] Out_data,
  output logic              Frame_done
);

  localparam int XW = cnt_w(COLS);
  localparam int YW = cnt_w(ROWS);
  localparam int ZW = cnt_w(LAYERS);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);
  localparam logic [ZW-1:0] Z_MAX = ZW'(LAYERS - 1);

  logic [XW-1:0]     x_q, x_d, x_cur;
  logic [YW-1:0]     y_q, y_d, y_cur;
  logic [ZW-1:0]     z_q, z_d, z_cur;
  mode_e             mode_q, mode_d, mode_cur;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;

  logic              accept;
  logic              at_origin;
  logic              is_last;
  logic [ADDR_W-1:0] addr_cur;

  assign In_ready = !out_valid_q || Out_ready;
  assign accept   = In_valid && In_ready;

  // An sof beat forces index 0 no matter where the counter has drifted to.
  always_comb begin
    x_cur     = In_sof ? '0 : x_q;
    y_cur     = In_sof ? '0 : y_q;
    z_cur     = In_sof ? '0 : z_q;
    at_origin = (x_cur == '0) && (y_cur == '0) && (z_cur == '0);
    is_last   = (x_cur == X_MAX) && (y_cur == Y_MAX) && (z_cur == Z_MAX);
    mode_cur  = at_origin ? mode_e'(Mode) : mode_q;
  end

  led_addr_calc #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .LAYERS (LAYERS)
  ) u_calc (
    .x_i    (x_cur),
    .y_i    (y_cur),
    .z_i    (z_cur),
    .mode_i (mode_cur),
    .addr_o (addr_cur)
  );

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    mode_d = mode_q;
    if (accept) begin
      mode_d = mode_cur;
      x_d    = x_cur + XW'(1);
      y_d    = y_cur;
      z_d    = z_cur;
      if (x_cur == X_MAX) begin
        x_d = '0;
        if (y_cur == Y_MAX) begin
          y_d = '0;
          z_d = (z_cur == Z_MAX) ? '0 : z_cur + ZW'(1);
        end else begin
          y_d = y_cur + YW'(1);
        end
      end
    end
  end

  // Output stage reloads whenever it is empty or draining, so accept-in and
  // accept-out in the same cycle keep full throughput.
  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (In_ready) begin
      out_valid_d = In_valid;
      if (accept) begin
        out_addr_d = addr_cur;
        out_data_d = In_data;
        out_last_d = is_last;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mode_q      <= MODE_LINEAR;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign Out_valid  = out_valid_q;
  assign Out_addr   = out_addr_q;
  assign Out_data   = out_data_q;
  // Only the completing handshake pulses, so a stalled last beat cannot fire twice.
  assign Frame_done = out_valid_q && Out_ready && out_last_q;

endmodule

// File: tb/tb_led_addr_mapper.sv
// Directed bench for led_addr_mapper (8x8x8, 24-bit data) with immediate-assertion checks.
module tb_led_addr_mapper;

  localparam int AW = 9;
  localparam int DW = 24;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [1:0]    Mode;
  logic          In_valid;
  logic          In_ready;
  logic          In_sof;
  logic [DW-1:0] In_data;
  logic          Out_valid;
  logic          Out_ready;
  logic [AW-1:0] Out_addr;
  logic [DW-1:0] Out_data;
  logic          Frame_done;

  int total = 0;
  int bad   = 0;
  int fd_cnt = 0;
  int fd0;

  led_addr_mapper #(
    .COLS   (8),
    .ROWS   (8),
    .LAYERS (8),
    .DATA_W (DW)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Mode       (Mode),
    .In_valid   (In_valid),
    .In_ready   (In_ready),
    .In_sof     (In_sof),
    .In_data    (In_data),
    .Out_valid  (Out_valid),
    .Out_ready  (Out_ready),
    .Out_addr   (Out_addr),
    .Out_data   (Out_data),
    .Frame_done (Frame_done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) if (Frame_done === 1'b1) fd_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit sof, input logic [DW-1:0] d, input bit do_chk,
                      input logic [AW-1:0] exp_a, input string tag);
    @(negedge Clk);
    In_valid = 1'b1;
    In_sof   = sof;
    In_data  = d;
    @(posedge Clk);
    #1;
    In_sof = 1'b0;
    if (do_chk) begin
      chk({tag, "_valid"}, 32'(Out_valid), 32'd1);
      chk({tag, "_addr"},  32'(Out_addr),  32'(exp_a));
      chk({tag, "_data"},  32'(Out_data),  32'(d));
    end
  endtask

  task automatic idle();
    @(negedge Clk);
    In_valid = 1'b0;
    In_sof   = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Mode = 2'b00; In_valid = 1'b0; In_sof = 1'b0;
    In_data = '0; Out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_valid", 32'(Out_valid), 32'd0);
    chk("rst_addr",  32'(Out_addr),  32'd0);
    chk("rst_data",  32'(Out_data),  32'd0);
    chk("rst_fd",    32'(Frame_done), 32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("rst_inready", 32'(In_ready), 32'd1);

    // row serpentine: 0..7 then 15 down to 8, back to back
    Mode = 2'b01;
    for (int i = 0; i < 16; i++)
      send(i == 0, DW'(24'h010000 + i), 1'b1, AW'((i < 8) ? i : 23 - i), $sformatf("m01_%0d", i));
    idle();

    // column serpentine
    Mode = 2'b10;
    send(1'b1, 24'h020000, 1'b1, 9'd0,  "m10_0");
    send(1'b0, 24'h020001, 1'b1, 9'd15, "m10_1");
    send(1'b0, 24'h020002, 1'b1, 9'd16, "m10_2");
    idle();

    // cube serpentine: odd layer reversed
    Mode = 2'b11;
    send(1'b1, 24'h030000, 1'b1, 9'd0, "m11_0");
    for (int i = 1; i < 64; i++)
      send(1'b0, DW'(24'h030000 + i), 1'b0, 9'd0, "m11_fill");
    send(1'b0, 24'h030040, 1'b1, 9'd127, "m11_64");
    send(1'b0, 24'h030041, 1'b1, 9'd126, "m11_65");
    idle();

    // backpressure
    Mode = 2'b00;
    send(1'b1, 24'h0B0000, 1'b1, 9'd0, "bp_0");
    @(negedge Clk);
    Out_ready = 1'b0;
    In_valid  = 1'b1;
    In_data   = 24'h0B0001;
    #1;
    chk("bp_inready_low", 32'(In_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk);
      #1;
      chk($sformatf("bp_hold_addr_%0d", c),  32'(Out_addr),  32'd0);
      chk($sformatf("bp_hold_data_%0d", c),  32'(Out_data),  32'h0B0000);
      chk($sformatf("bp_hold_valid_%0d", c), 32'(Out_valid), 32'd1);
      chk($sformatf("bp_hold_rdy_%0d", c),   32'(In_ready),  32'd0);
    end
    @(negedge Clk);
    Out_ready = 1'b1;
    @(posedge Clk);
    #1;
    chk("bp_rel_addr", 32'(Out_addr), 32'd1);
    chk("bp_rel_data", 32'(Out_data), 32'h0B0001);
    send(1'b0, 24'h0B0002, 1'b1, 9'd2, "bp_2");
    send(1'b0, 24'h0B0003, 1'b1, 9'd3, "bp_3");
    idle();

    // full linear frame, mode toggled mid-frame, stalled last beat
    Mode = 2'b00;
    fd0 = fd_cnt;
    for (int i = 0; i < 512; i++) begin
      if (i == 200) Mode = 2'b01;
      send(i == 0, DW'(24'h400000 + i), 1'b1, AW'(i), $sformatf("lin_%0d", i));
      if (i == 511) chk("fd_on_last", 32'(Frame_done), 32'd1);
    end
    @(negedge Clk);
    In_valid  = 1'b0;
    Out_ready = 1'b0;
    #1;
    chk("fd_stall0", 32'(Frame_done), 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    chk("fd_stall_addr",  32'(Out_addr),   32'd511);
    chk("fd_stall_valid", 32'(Out_valid),  32'd1);
    chk("fd_stall1",      32'(Frame_done), 32'd0);
    @(negedge Clk);
    Out_ready = 1'b1;
    #1;
    chk("fd_release", 32'(Frame_done), 32'd1);
    send(1'b0, 24'h500000, 1'b1, 9'd0, "wrap_0");
    for (int k = 1; k <= 8; k++)
      send(1'b0, DW'(24'h500000 + k), 1'b1, AW'((k < 8) ? k : 15), $sformatf("wrap_%0d", k));
    idle();
    repeat (2) @(posedge Clk);
    #1;
    chk("fd_once", 32'(fd_cnt - fd0), 32'd1);

    // sof mid-frame truncates without Frame_done
    Mode = 2'b00;
    fd0 = fd_cnt;
    for (int i = 0; i < 37; i++)
      send(i == 0, DW'(24'h600000 + i), 1'b1, AW'(i), $sformatf("pre_%0d", i));
    send(1'b1, 24'h600025, 1'b1, 9'd0, "sof37");
    send(1'b0, 24'h600026, 1'b1, 9'd1, "sof_1");
    send(1'b0, 24'h600027, 1'b1, 9'd2, "sof_2");
    idle();
    repeat (2) @(posedge Clk);
    #1;
    chk("sof_no_fd", 32'(fd_cnt - fd0), 32'd0);

    // reset mid-frame with a beat in flight
    send(1'b0, 24'h700003, 1'b1, 9'd3, "prerst");
    @(negedge Clk);
    In_valid = 1'b0;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    chk("midrst_valid", 32'(Out_valid), 32'd0);
    chk("midrst_addr",  32'(Out_addr),  32'd0);
    @(negedge Clk);
    Rst = 1'b0;
    send(1'b0, 24'h710000, 1'b1, 9'd0, "postrst_0");
    send(1'b0, 24'h710001, 1'b1, 9'd1, "postrst_1");
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
